r512x16_fifo_ctl: RTL and testbench

- Single-clock FIFO controller that drives both ports of the 512x16 block RAM wrapper and turns it into a push/valid-ready stream FIFO.
- Upstream side: Push/Push_Data with a Full back-pressure flag.
- Downstream side: registered Out_Valid/Out_Ready stream, fed from RAM RD through a 2-entry output buffer.
- At top level, RAM WClk and RClk both tie to Clk.

---
 rtl/r512x16_fifo_pkg.sv | 10 +
 rtl/r512x16_fifo_outbuf.sv | 57 +++++
 rtl/r512x16_fifo_ctl.sv | 125 ++++++++++++
 tb/tb_r512x16_fifo_ctl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/r512x16_fifo_pkg.sv
// Shared constants and word/pointer types for the 512x16 stream FIFO controller.
package r512x16_fifo_pkg;
  localparam int FIFO_ADDR_W    = 9;
  localparam int FIFO_DEPTH     = 512;
  localparam int FIFO_DATA_W    = 16;
  localparam int OUTBUF_ENTRIES = 2;

  typedef logic [FIFO_DATA_W-1:0] fifo_word_t;
  typedef logic [FIFO_ADDR_W-1:0] fifo_ptr_t;
endpackage

// File: rtl/r512x16_fifo_outbuf.sv
// Two-entry registered output buffer between RAM read data and the valid/ready stream.
module r512x16_fifo_outbuf
  import r512x16_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  fifo_word_t load_data,
  input  logic       pop,
  output logic [1:0] buf_cnt,
  output logic       out_valid,
  output fifo_word_t out_data
);

  fifo_word_t head_q, head_d;
  fifo_word_t tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic       pop_eff;

  // Pop shifts the tail forward first, so a simultaneous load lands behind the survivor.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    pop_eff = pop & valid_q;
    if (pop_eff) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (load) begin
      if (cnt_d == 2'd0) head_d = load_data;
      else               tail_d = load_data;
      cnt_d = cnt_d + 2'd1;
    end
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign buf_cnt   = cnt_q;
  assign out_valid = valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/r512x16_fifo_ctl.sv
// Stream FIFO controller over a 512x16 dual-port RAM; define R512X16_FIFO_OVF_CHK_EN
// to build the sticky Overflow detector (otherwise Overflow is tied low).
module r512x16_fifo_ctl
  import r512x16_fifo_pkg::*;
#(
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int AFULL_TH  = 480,
  parameter int AEMPTY_TH = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Push,
  input  logic [DATA_W-1:0] Push_Data,
  output logic              Full,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [ADDR_W+1:0] Count,
  output logic              Almost_Full,
  output logic              Almost_Empty,
  output logic              Overflow,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] WD,
  output logic [1:0]        WEN,
  output logic              WClk_En,
  output logic [ADDR_W-1:0] RA,
  output logic              RClk_En,
  input  logic [DATA_W-1:0] RD
);

  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W+1:0] AFULL_V  = (ADDR_W+2)'(AFULL_TH);
  localparam logic [ADDR_W+1:0] AEMPTY_V = (ADDR_W+2)'(AEMPTY_TH);

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W+1:0] count_q, count_d;
  logic              full_q, full_d, afull_q, afull_d, aempty_q, aempty_d;
  logic              push_acc, rd_issue, pop;
  logic [1:0]        buf_cnt;
  logic [2:0]        buf_occ;

  // RAM accesses are suppressed while reset is asserted so nothing is written mid-reset.
  always_comb begin
    pop        = Out_Valid & Out_Ready;
    push_acc   = Rst_n & Push & ~full_q;
    buf_occ    = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    rd_issue   = Rst_n & (ram_cnt_q != '0) & (buf_occ < 3'(OUTBUF_ENTRIES));
    wptr_d     = push_acc ? wptr_q + ADDR_W'(1) : wptr_q;
    rptr_d     = rd_issue ? rptr_q + ADDR_W'(1) : rptr_q;
    inflight_d = rd_issue;
    ram_cnt_d  = ram_cnt_q;
    if (push_acc && !rd_issue)      ram_cnt_d = ram_cnt_q + (ADDR_W+1)'(1);
    else if (!push_acc && rd_issue) ram_cnt_d = ram_cnt_q - (ADDR_W+1)'(1);
    count_d  = (ADDR_W+2)'(ram_cnt_d) + (ADDR_W+2)'(inflight_d) + (ADDR_W+2)'(buf_occ);
    full_d   = (ram_cnt_d == DEPTH_V);
    afull_d  = (count_d >= AFULL_V);
    aempty_d = (count_d <= AEMPTY_V);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

  r512x16_fifo_outbuf u_outbuf (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .load      (inflight_q),
    .load_data (RD),
    .pop       (pop),
    .buf_cnt   (buf_cnt),
    .out_valid (Out_Valid),
    .out_data  (Out_Data)
  );

`ifdef R512X16_FIFO_OVF_CHK_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (Push & full_q);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign Overflow = ovf_q;
`else
  assign Overflow = 1'b0;
`endif

  assign Full         = full_q;
  assign Count        = count_q;
  assign Almost_Full  = afull_q;
  assign Almost_Empty = aempty_q;
  assign WA           = wptr_q;
  assign WD           = Push_Data;
  assign WEN          = {2{push_acc}};
  assign WClk_En      = push_acc;
  assign RA           = rptr_q;
  assign RClk_En      = rd_issue;

endmodule

// File: tb/tb_r512x16_fifo_ctl.sv
// Directed and scoreboarded bench for r512x16_fifo_ctl with a behavioural 512x16 RAM.
module tb_r512x16_fifo_ctl;
  import r512x16_fifo_pkg::*;

  logic        Clk, Rst_n, Push, Out_Ready;
  fifo_word_t  Push_Data, Out_Data, WD, RD;
  logic        Full, Out_Valid, Almost_Full, Almost_Empty, Overflow;
  logic [10:0] Count;
  fifo_ptr_t   WA, RA;
  logic [1:0]  WEN;
  logic        WClk_En, RClk_En;

  int total = 0;
  int bad   = 0;
  fifo_word_t mem [512];
  fifo_word_t q [$];

`ifdef R512X16_FIFO_OVF_CHK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  r512x16_fifo_ctl dut (
    .Clk(Clk), .Rst_n(Rst_n), .Push(Push), .Push_Data(Push_Data), .Full(Full),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data), .Count(Count),
    .Almost_Full(Almost_Full), .Almost_Empty(Almost_Empty), .Overflow(Overflow),
    .WA(WA), .WD(WD), .WEN(WEN), .WClk_En(WClk_En), .RA(RA), .RClk_En(RClk_En), .RD(RD)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Byte-enabled write port and registered read port, as the real RAM wrapper behaves.
  always @(posedge Clk) begin
    if (WClk_En) begin
      if (WEN[0]) mem[WA][7:0]  <= WD[7:0];
      if (WEN[1]) mem[WA][15:8] <= WD[15:8];
    end
    if (RClk_En) RD <= mem[RA];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    logic seen;
    Rst_n = 1'b0; Push = 1'b0; Out_Ready = 1'b0; Push_Data = '0;
    tick; tick;
    Rst_n = 1'b1; #1;
    total++; if (Full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b expected 0", Full); end
    total++; if (Out_Valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", Out_Valid); end
    total++; if (Count !== 11'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", Count); end
    total++; if (Almost_Empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_aempty: got %b expected 1", Almost_Empty); end
    total++; if (Almost_Full !== 1'b0) begin bad++; $display("[TB] FAIL reset_afull: got %b expected 0", Almost_Full); end
    total++; if (Overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b expected 0", Overflow); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick; #1;
      if (WClk_En !== 1'b0 || RClk_En !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL idle_ram_access: got %b expected 0", seen); end
  endtask

  task automatic test_single;
    Out_Ready = 1'b1;
    tick; Push = 1'b1; Push_Data = 16'hA5A5; #1;
    total++; if (WA !== 9'd0) begin bad++; $display("[TB] FAIL single_wa: got %0d expected 0", WA); end
    total++; if (WEN !== 2'b11) begin bad++; $display("[TB] FAIL single_wen: got %b expected 11", WEN); end
    tick; Push = 1'b0; #1;
    total++; if (RClk_En !== 1'b1) begin bad++; $display("[TB] FAIL single_rclk_en: got %b expected 1", RClk_En); end
    total++; if (RA !== 9'd0) begin bad++; $display("[TB] FAIL single_ra: got %0d expected 0", RA); end
    total++; if (Count !== 11'd1) begin bad++; $display("[TB] FAIL single_count: got %0d expected 1", Count); end
    tick; #1;
    total++; if (Out_Valid !== 1'b0) begin bad++; $display("[TB] FAIL single_early_valid: got %b expected 0", Out_Valid); end
    tick; #1;
    total++; if (Out_Valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid: got %b expected 1", Out_Valid); end
    total++; if (Out_Data !== 16'hA5A5) begin bad++; $display("[TB] FAIL single_data: got %h expected a5a5", Out_Data); end
    tick; #1;
    total++; if (Out_Valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_after_pop: got %b expected 0", Out_Valid); end
    total++; if (Count !== 11'd0) begin bad++; $display("[TB] FAIL single_count_after_pop: got %0d expected 0", Count); end
  endtask

  task automatic test_fill;
    int exp_w;
    Out_Ready = 1'b0;
    for (int i = 0; i < 514; i++) begin
      tick; Push = 1'b1; Push_Data = 16'(i); #1;
      total++; if (Count !== 11'(i)) begin bad++; $display("[TB] FAIL fill_count: got %0d expected %0d", Count, i); end
      total++; if (Full !== 1'b0) begin bad++; $display("[TB] FAIL fill_full_early: got %b expected 0 at %0d", Full, i); end
      total++; if (Almost_Full !== (i >= 480)) begin bad++; $display("[TB] FAIL fill_afull: got %b at count %0d", Almost_Full, i); end
      total++; if (Almost_Empty !== (i <= 32)) begin bad++; $display("[TB] FAIL fill_aempty: got %b at count %0d", Almost_Empty, i); end
    end
    tick; Push = 1'b1; Push_Data = 16'hFFFF; #1;
    total++; if (Count !== 11'd514) begin bad++; $display("[TB] FAIL fill_count_max: got %0d expected 514", Count); end
    total++; if (Full !== 1'b1) begin bad++; $display("[TB] FAIL fill_full: got %b expected 1", Full); end
    total++; if (WClk_En !== 1'b0) begin bad++; $display("[TB] FAIL fill_push_ignored: got %b expected 0", WClk_En); end
    tick; Push = 1'b0; #1;
    total++; if (Count !== 11'd514) begin bad++; $display("[TB] FAIL fill_count_hold: got %0d expected 514", Count); end
    total++; if (Overflow !== OVF_EXP) begin bad++; $display("[TB] FAIL fill_overflow: got %b expected %b", Overflow, OVF_EXP); end
    Out_Ready = 1'b1;
    exp_w = 0;
    for (int c = 0; c < 700 && exp_w < 514; c++) begin
      if (Out_Valid === 1'b1) begin
        total++; if (Out_Data !== 16'(exp_w)) begin bad++; $display("[TB] FAIL drain_data: got %h expected %h", Out_Data, 16'(exp_w)); end
        exp_w++;
      end
      tick; #1;
    end
    total++; if (exp_w != 514) begin bad++; $display("[TB] FAIL drain_words: got %0d expected 514", exp_w); end
    total++; if (Out_Valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_valid_end: got %b expected 0", Out_Valid); end
    total++; if (Count !== 11'd0) begin bad++; $display("[TB] FAIL drain_count_end: got %0d expected 0", Count); end
  endtask

  task automatic test_wrap;
    int sent, recv, first_c, last_c;
    logic wa511, ra511, wa_wrap, ra_wrap;
    fifo_word_t exp_d;
    sent = 0; recv = 0; first_c = -1; last_c = -1;
    wa511 = 0; ra511 = 0; wa_wrap = 0; ra_wrap = 0;
    q.delete();
    Out_Ready = 1'b1;
    for (int c = 0; c < 1200 && recv < 1000; c++) begin
      tick;
      Push = (sent < 1000); Push_Data = 16'(sent + 16'h1000); #1;
      if (WClk_En && wa511 && WA == 9'd0) wa_wrap = 1'b1;
      if (WClk_En && WA == 9'd511) wa511 = 1'b1;
      if (RClk_En && ra511 && RA == 9'd0) ra_wrap = 1'b1;
      if (RClk_En && RA == 9'd511) ra511 = 1'b1;
      if (Push && !Full) begin q.push_back(Push_Data); sent++; end
      if (Out_Valid && Out_Ready) begin
        if (q.size() == 0) begin
          total++; bad++; $display("[TB] FAIL wrap_dup: got %h expected nothing", Out_Data);
        end else begin
          exp_d = q.pop_front();
          total++; if (Out_Data !== exp_d) begin bad++; $display("[TB] FAIL wrap_data: got %h expected %h", Out_Data, exp_d); end
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        recv++;
      end
    end
    Push = 1'b0;
    total++; if (recv != 1000) begin bad++; $display("[TB] FAIL wrap_count: got %0d expected 1000", recv); end
    total++; if (last_c - first_c != 999) begin bad++; $display("[TB] FAIL wrap_rate: got span %0d expected 999", last_c - first_c); end
    total++; if (wa_wrap !== 1'b1) begin bad++; $display("[TB] FAIL wrap_wa: got %b expected 1", wa_wrap); end
    total++; if (ra_wrap !== 1'b1) begin bad++; $display("[TB] FAIL wrap_ra: got %b expected 1", ra_wrap); end
  endtask

  task automatic test_random;
    logic prev_stall;
    fifo_word_t prev_data, exp_d;
    q.delete();
    prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 5700; c++) begin
      tick;
      if (c < 5000) begin
        Push = 1'($urandom_range(0, 1)); Push_Data = 16'($urandom); Out_Ready = 1'($urandom_range(0, 1));
      end else begin
        Push = 1'b0; Out_Ready = 1'b1;
      end
      #1;
      total++; if (Count !== 11'(q.size())) begin bad++; $display("[TB] FAIL rand_count: got %0d expected %0d", Count, q.size()); end
      if (prev_stall) begin
        total++; if (Out_Valid !== 1'b1 || Out_Data !== prev_data) begin bad++; $display("[TB] FAIL rand_stable: got %b/%h expected 1/%h", Out_Valid, Out_Data, prev_data); end
      end
      if (Push && !Full) q.push_back(Push_Data);
      if (Out_Valid && Out_Ready) begin
        if (q.size() == 0) begin
          total++; bad++; $display("[TB] FAIL rand_dup: got %h expected nothing", Out_Data);
        end else begin
          exp_d = q.pop_front();
          total++; if (Out_Data !== exp_d) begin bad++; $display("[TB] FAIL rand_data: got %h expected %h", Out_Data, exp_d); end
        end
      end
      prev_stall = Out_Valid & ~Out_Ready;
      prev_data  = Out_Data;
    end
    total++; if (q.size() != 0) begin bad++; $display("[TB] FAIL rand_loss: got %0d words left expected 0", q.size()); end
    total++; if (Out_Valid !== 1'b0) begin bad++; $display("[TB] FAIL rand_valid_end: got %b expected 0", Out_Valid); end
  endtask

  task automatic test_midreset;
    logic got;
    tick; Rst_n = 1'b0; Push = 1'b0; Out_Ready = 1'b0;
    tick; Rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick; Push = 1'b1; Push_Data = 16'(i + 16'h2000);
    end
    tick; Push = 1'b0; #1;
    total++; if (Count !== 11'd100) begin bad++; $display("[TB] FAIL mid_count_before: got %0d expected 100", Count); end
    tick; Rst_n = 1'b0; Push = 1'b1; Push_Data = 16'h1234; Out_Ready = 1'b1; #1;
    total++; if (WClk_En !== 1'b0 || RClk_En !== 1'b0) begin bad++; $display("[TB] FAIL mid_ram_access: got %b%b expected 00", WClk_En, RClk_En); end
    tick; Rst_n = 1'b1; Push = 1'b0; #1;
    total++; if (Count !== 11'd0) begin bad++; $display("[TB] FAIL mid_count_after: got %0d expected 0", Count); end
    total++; if (Out_Valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid_after: got %b expected 0", Out_Valid); end
    total++; if (Full !== 1'b0) begin bad++; $display("[TB] FAIL mid_full_after: got %b expected 0", Full); end
    total++; if (Overflow !== 1'b0) begin bad++; $display("[TB] FAIL mid_ovf_after: got %b expected 0", Overflow); end
    tick; Push = 1'b1; Push_Data = 16'hBEEF; #1;
    total++; if (WA !== 9'd0 || WClk_En !== 1'b1) begin bad++; $display("[TB] FAIL mid_first_wa: got %0d/%b expected 0/1", WA, WClk_En); end
    tick; Push = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      tick; #1;
      if (Out_Valid === 1'b1) got = 1'b1;
    end
    total++; if (got !== 1'b1 || Out_Data !== 16'hBEEF) begin bad++; $display("[TB] FAIL mid_first_data: got %b/%h expected 1/beef", got, Out_Data); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_wrap;
    test_random;
    test_midreset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
